// File: rtl/ok_trigger_dispatch_pkg.sv
// Shared types and helpers for the trigger dispatch block.
// Holds the FSM encoding and the width-check function.
package ok_trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_t;

  localparam int TRIG_W_DEF = 32;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ok_trigger_dispatch_if.sv
// Command handshake between the dispatcher and user logic.
// The master drives valid/id and the slave returns ready.
interface ok_trigger_dispatch_if #(
  parameter int ID_W = 5
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [ID_W-1:0] cmd_id;

  modport master (
    output cmd_valid,
    output cmd_id,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_id,
    output cmd_ready
  );
endinterface

// File: rtl/ok_trigger_dispatch_prio_enc.sv
// Lowest-set-bit priority encoder.
// Gives index and one-hot of the winning bit.
module ok_trig_prio_enc #(
  parameter int TRIG_W = 32,
  parameter int ID_W   = 5
) (
  input  logic [TRIG_W-1:0] in,
  output logic              any,
  output logic [ID_W-1:0]   idx,
  output logic [TRIG_W-1:0] onehot
);

  always_comb begin
    any = |in;
    idx = '0;
    for (int i = TRIG_W - 1; i >= 0; i--) begin
      if (in[i]) idx = ID_W'(i);
    end
  end

  assign onehot = in & (~in + TRIG_W'(1));

endmodule

// File: rtl/ok_trigger_dispatch.sv
// Serialises Trigger In pulses into one-at-a-time command ids.
// Pending/overflow tracking plus an optional post-accept holdoff.
module ok_trigger_dispatch
  import ok_trig_pkg::*;
#(
  parameter int TRIG_W         = TRIG_W_DEF,
  parameter int ID_W           = 5,
  parameter int HOLDOFF_CYCLES = 0
) (
  input  logic                  ep_clk,
  input  logic                  ti_reset,
  input  logic [TRIG_W-1:0]     ep_trigger,
  input  logic [TRIG_W-1:0]     ovf_clear,
  ok_trigger_dispatch_if.master cmd,
  output logic [TRIG_W-1:0]     pending,
  output logic [TRIG_W-1:0]     overflow,
  output logic                  busy
);

  if (ID_W != clog2_min1(TRIG_W)) begin : g_id_chk
    $error("ID_W must equal clog2(TRIG_W)");
  end

  trig_state_t state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic              valid_q, valid_n;
  logic [ID_W-1:0]   id_q;
  logic              load;
  logic [TRIG_W-1:0] cand;
  logic              any;
  logic [ID_W-1:0]   sel;
  logic [TRIG_W-1:0] sel_oh;
  logic              accept;

  assign cand   = pending | ep_trigger;
  assign accept = valid_q & cmd.cmd_ready;

  ok_trig_prio_enc #(
    .TRIG_W (TRIG_W),
    .ID_W   (ID_W)
  ) u_enc (
    .in     (cand),
    .any    (any),
    .idx    (sel),
    .onehot (sel_oh)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = valid_q;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          load    = 1'b1;
          valid_n = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (HOLDOFF_CYCLES > 0) begin
            state_n = HOLDOFF;
            cnt_n   = 8'(HOLDOFF_CYCLES - 1);
            valid_n = 1'b0;
          end else if (any) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
          end
        end
      end
      HOLDOFF: begin
        // Reload straight from the last holdoff cycle so valid is
        // low for exactly HOLDOFF_CYCLES cycles.
        if (cnt == 8'd0) begin
          if (any) begin
            load    = 1'b1;
            valid_n = 1'b1;
            state_n = ISSUE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ep_clk or posedge ti_reset) begin
    if (ti_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      valid_q  <= valid_n;
      if (load) id_q <= sel;
      pending  <= cand & ~(load ? sel_oh : '0);
      overflow <= (ep_trigger & pending) | (overflow & ~ovf_clear);
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_id    = id_q;
  assign busy          = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_ok_trigger_dispatch.sv
// Directed self-checking bench for ok_trigger_dispatch.
// Two instances: no holdoff and a 4-cycle holdoff.
module tb_ok_trigger_dispatch;

  logic        ep_clk = 1'b0;
  logic        ti_reset;
  logic [31:0] trig0, clr0, trig4, clr4;
  logic [31:0] pend0, ovf0, pend4, ovf4;
  logic        busy0, busy4;
  int          tests = 0;
  int          fails = 0;

  ok_trigger_dispatch_if #(.ID_W(5)) bus0 ();
  ok_trigger_dispatch_if #(.ID_W(5)) bus4 ();

  always #5 ep_clk = ~ep_clk;

  ok_trigger_dispatch #(
    .TRIG_W(32), .ID_W(5), .HOLDOFF_CYCLES(0)
  ) dut0 (
    .ep_clk(ep_clk), .ti_reset(ti_reset),
    .ep_trigger(trig0), .ovf_clear(clr0),
    .cmd(bus0), .pending(pend0),
    .overflow(ovf0), .busy(busy0)
  );

  ok_trigger_dispatch #(
    .TRIG_W(32), .ID_W(5), .HOLDOFF_CYCLES(4)
  ) dut4 (
    .ep_clk(ep_clk), .ti_reset(ti_reset),
    .ep_trigger(trig4), .ovf_clear(clr4),
    .cmd(bus4), .pending(pend4),
    .overflow(ovf4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ep_clk);
    #1;
  endtask

  initial begin
    ti_reset = 1'b1;
    trig0 = '0; clr0 = '0; trig4 = '0; clr4 = '0;
    bus0.cmd_ready = 1'b0;
    bus4.cmd_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus0.cmd_valid), 32'd0);
    chk("rst_id", 32'(bus0.cmd_id), 32'd0);
    chk("rst_pend", pend0, 32'd0);
    chk("rst_ovf", ovf0, 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    ti_reset = 1'b0;
    tick();

    // single trigger, consumer always ready
    trig0 = 32'h0000_0001;
    bus0.cmd_ready = 1'b1;
    tick();
    trig0 = '0;
    chk("t1_valid", 32'(bus0.cmd_valid), 32'd1);
    chk("t1_id", 32'(bus0.cmd_id), 32'd0);
    chk("t1_pend", pend0, 32'd0);
    tick();
    chk("t1_pulse", 32'(bus0.cmd_valid), 32'd0);
    chk("t1_ovf", ovf0, 32'd0);
    chk("t1_busy", 32'(busy0), 32'd0);

    // multi-bit word, stalled then drained back-to-back
    bus0.cmd_ready = 1'b0;
    trig0 = 32'h8000_0011;
    tick();
    trig0 = '0;
    chk("t2_hold_id", 32'(bus0.cmd_id), 32'd0);
    chk("t2_hold_pend", pend0, 32'h8000_0010);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_hold_v", 32'(bus0.cmd_valid), 32'd1);
      chk("t2_hold_id", 32'(bus0.cmd_id), 32'd0);
      chk("t2_hold_pend", pend0, 32'h8000_0010);
    end
    bus0.cmd_ready = 1'b1;
    tick();
    chk("t2_v4", 32'(bus0.cmd_valid), 32'd1);
    chk("t2_id4", 32'(bus0.cmd_id), 32'd4);
    chk("t2_pend4", pend0, 32'h8000_0000);
    tick();
    chk("t2_v31", 32'(bus0.cmd_valid), 32'd1);
    chk("t2_id31", 32'(bus0.cmd_id), 32'd31);
    chk("t2_pend31", pend0, 32'd0);
    tick();
    chk("t2_done", 32'(bus0.cmd_valid), 32'd0);
    bus0.cmd_ready = 1'b0;

    // re-pend while in flight, then overflow and clear
    trig0 = 32'h8;
    tick();
    trig0 = '0;
    chk("t3_id", 32'(bus0.cmd_id), 32'd3);
    chk("t3_pend0", pend0, 32'd0);
    tick();
    trig0 = 32'h8;
    tick();
    trig0 = '0;
    chk("t3_repend", pend0, 32'h8);
    chk("t3_no_ovf", ovf0, 32'd0);
    tick();
    trig0 = 32'h8;
    tick();
    trig0 = '0;
    chk("t3_ovf", ovf0, 32'h8);
    chk("t3_id_held", 32'(bus0.cmd_id), 32'd3);
    clr0 = 32'h8;
    tick();
    clr0 = '0;
    chk("t3_clr", ovf0, 32'd0);
    bus0.cmd_ready = 1'b1;
    tick();
    chk("t3_reissue", 32'(bus0.cmd_id), 32'd3);
    chk("t3_reissue_v", 32'(bus0.cmd_valid), 32'd1);
    tick();
    chk("t3_idle", 32'(bus0.cmd_valid), 32'd0);
    chk("t3_busy", 32'(busy0), 32'd0);
    bus0.cmd_ready = 1'b0;

    // set beats clear on the same edge
    trig0 = 32'h20;
    tick();
    chk("t6_id", 32'(bus0.cmd_id), 32'd5);
    tick();
    chk("t6_pend", pend0, 32'h20);
    clr0 = 32'h20;
    tick();
    trig0 = '0;
    clr0 = '0;
    chk("t6_set_wins", ovf0, 32'h20);

    // holdoff instance
    trig4 = 32'h6;
    bus4.cmd_ready = 1'b1;
    tick();
    trig4 = '0;
    chk("t4_id1", 32'(bus4.cmd_id), 32'd1);
    chk("t4_v1", 32'(bus4.cmd_valid), 32'd1);
    chk("t4_busy1", 32'(busy4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_gap_v", 32'(bus4.cmd_valid), 32'd0);
      chk("t4_gap_busy", 32'(busy4), 32'd1);
    end
    tick();
    chk("t4_v2", 32'(bus4.cmd_valid), 32'd1);
    chk("t4_id2", 32'(bus4.cmd_id), 32'd2);
    tick();
    chk("t4_v2_done", 32'(bus4.cmd_valid), 32'd0);
    chk("t4_busy_ho", 32'(busy4), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_busy_end", 32'(busy4), 32'd0);
    chk("t4_v_end", 32'(bus4.cmd_valid), 32'd0);
    bus4.cmd_ready = 1'b0;

    // async reset mid-issue with F00 pending
    bus0.cmd_ready = 1'b1;
    tick();
    bus0.cmd_ready = 1'b0;
    chk("t5_pre_clr", pend0, 32'd0);
    trig0 = 32'h0000_0F00;
    tick();
    trig0 = '0;
    chk("t5_pend", pend0, 32'h0000_0F00);
    chk("t5_v", 32'(bus0.cmd_valid), 32'd1);
    #2;
    ti_reset = 1'b1;
    #1;
    chk("t5_async_v", 32'(bus0.cmd_valid), 32'd0);
    chk("t5_async_id", 32'(bus0.cmd_id), 32'd0);
    chk("t5_async_pend", pend0, 32'd0);
    chk("t5_async_ovf", ovf0, 32'd0);
    chk("t5_async_busy", 32'(busy0), 32'd0);
    @(negedge ep_clk);
    ti_reset = 1'b0;
    bus0.cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_quiet", 32'(bus0.cmd_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
